trapez_energy_sampler: RTL

Downstream consumer of the trapezoidal shaper output. On each accepted pulse trigger it waits out the shaper pipeline latency and the rise time, then averages 2^avg_log2 samples on the flat top and emits one signed energy word over a valid/ready handshake. It also flags pile-up, counts results dropped under back-pressure, and flags windows that overrun the flat top.

---
 rtl/trapez_energy_sampler_pkg.sv | 20 ++
 rtl/trapez_energy_out_reg.sv | 38 +++
 rtl/trapez_energy_sampler.sv | 121 ++++++++++++
 3 files changed

// File: rtl/trapez_energy_sampler_pkg.sv
// Shared types and constants for the trapezoidal-shaper energy sampler.
// Pure declarations; no latency or flow control of its own.
package trapez_energy_sampler_pkg;

    localparam int SIZE_SHAPER_DATA       = 16;
    localparam int SIZE_SHAPER_CONSTANT   = 10;
    localparam int SHAPER_LATENCY_DEFAULT = 9;

    typedef enum logic [1:0] {
        IDLE,
        RISE,
        ACCUM
    } sampler_state_t;

    // Window exponents above the accumulator headroom are pinned to the maximum.
    function automatic logic [2:0] clamp_avg(input logic [2:0] a, input int max_log2);
        return (int'(a) > max_log2) ? 3'(max_log2) : a;
    endfunction

endpackage

// File: rtl/trapez_energy_out_reg.sv
// One-entry valid/ready result register; loads in the same cycle as the strobe, visible next cycle.
// While full and not being drained, new results are dropped and counted (saturating).
module trapez_energy_out_reg #(
    parameter int DATA_W = 16,
    parameter int LOST_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic signed [DATA_W-1:0] load_data,
    input  logic                     ready,
    output logic signed [DATA_W-1:0] data,
    output logic                     valid,
    output logic [LOST_W-1:0]        lost_count
);

    logic accept;

    assign accept = !valid || ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data       <= '0;
            valid      <= 1'b0;
            lost_count <= '0;
        end else begin
            if (load && accept) begin
                data  <= load_data;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (load && !accept && (lost_count != '1))
                lost_count <= lost_count + LOST_W'(1);
        end
    end

endmodule

// File: rtl/trapez_energy_sampler.sv
// Averages 2^avg_log2 flat-top samples per trigger; result valid at t0 + k + latency + offset + N.
// Output is a one-entry valid/ready register; results arriving while it is full are dropped and counted.
module trapez_energy_sampler
    import trapez_energy_sampler_pkg::*;
#(
    parameter int DATA_W         = SIZE_SHAPER_DATA,
    parameter int CONST_W        = SIZE_SHAPER_CONSTANT,
    parameter int SHAPER_LATENCY = SHAPER_LATENCY_DEFAULT,
    parameter int MAX_AVG_LOG2   = 4,
    parameter int LOST_W         = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic signed [DATA_W-1:0]  shaper_data,
    input  logic                      pulse_time,
    input  logic [CONST_W-1:0]        k_trapez,
    input  logic [CONST_W-1:0]        l_trapez,
    input  logic [CONST_W-1:0]        flat_offset,
    input  logic [2:0]                avg_log2,
    output logic signed [DATA_W-1:0]  energy,
    output logic                      energy_valid,
    input  logic                      energy_ready,
    output logic                      pileup,
    output logic                      config_err,
    output logic                      busy,
    output logic [LOST_W-1:0]         lost_count
);

    localparam int ACC_W  = DATA_W + MAX_AVG_LOG2;
    localparam int DCNT_W = CONST_W + 6;
    localparam int WCNT_W = MAX_AVG_LOG2 + 1;

    sampler_state_t           state;
    logic [DCNT_W-1:0]        dcnt;
    logic [WCNT_W-1:0]        wcnt;
    logic [2:0]               avg_q;
    logic signed [ACC_W-1:0]  acc;

    logic [2:0]               avg_new;
    logic [WCNT_W-1:0]        win_new;
    logic [DCNT_W-1:0]        delay_new;
    logic                     cfg_bad;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [DATA_W-1:0] result;
    logic                     last_cycle;
    logic                     done;

    always_comb begin
        avg_new    = clamp_avg(avg_log2, MAX_AVG_LOG2);
        win_new    = WCNT_W'(1) << avg_new;
        delay_new  = DCNT_W'(k_trapez) + DCNT_W'(SHAPER_LATENCY) + DCNT_W'(flat_offset) - DCNT_W'(1);
        cfg_bad    = (DCNT_W'(flat_offset) + DCNT_W'(win_new)) > DCNT_W'(l_trapez);
        acc_next   = acc + {{MAX_AVG_LOG2{shaper_data[DATA_W-1]}}, shaper_data};
        result     = DATA_W'(acc_next >>> avg_q);
        last_cycle = (state == ACCUM) && (wcnt == WCNT_W'(1));
        done       = last_cycle && enable;
    end

    assign busy = (state != IDLE);

    // A trigger on the final ACCUM cycle is a clean hand-over, not a pile-up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dcnt       <= '0;
            wcnt       <= '0;
            avg_q      <= '0;
            acc        <= '0;
            pileup     <= 1'b0;
            config_err <= 1'b0;
        end else begin
            pileup <= 1'b0;
            if (!enable) begin
                state <= IDLE;
            end else if (pulse_time) begin
                state <= RISE;
                dcnt  <= delay_new;
                avg_q <= avg_new;
                if (cfg_bad)
                    config_err <= 1'b1;
                if ((state != IDLE) && !last_cycle)
                    pileup <= 1'b1;
            end else begin
                unique case (state)
                    RISE: begin
                        if (dcnt <= DCNT_W'(1)) begin
                            state <= ACCUM;
                            wcnt  <= WCNT_W'(1) << avg_q;
                            acc   <= '0;
                        end else begin
                            dcnt <= dcnt - DCNT_W'(1);
                        end
                    end
                    ACCUM: begin
                        acc  <= acc_next;
                        wcnt <= wcnt - WCNT_W'(1);
                        if (last_cycle)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    trapez_energy_out_reg #(
        .DATA_W (DATA_W),
        .LOST_W (LOST_W)
    ) u_out_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (done),
        .load_data  (result),
        .ready      (energy_ready),
        .data       (energy),
        .valid      (energy_valid),
        .lost_count (lost_count)
    );

endmodule
